// File: rtl/axi_lite_arbiter.sv
// Two-requester round-robin arbiter in front of one AXI4-Lite master port.
// Ports: ACLK/ARESET; requester side req, req_we, req_addr, req_wdata,
//   req_ack, req_rdata, busy; AXI4-Lite AW/W/B/AR/R (no strobes, no resp).
module axi_lite_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_WIDTH  = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,

    input  logic [1:0]              req,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*REG_WIDTH-1:0]  req_wdata,
    output logic [1:0]              req_ack,
    output logic [REG_WIDTH-1:0]    req_rdata,
    output logic                    busy,

    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    WVALID,
    input  logic                    WREADY,
    output logic [REG_WIDTH-1:0]    WDATA,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    RVALID,
    output logic                    RREADY,
    input  logic [REG_WIDTH-1:0]    RDATA
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_DATA
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic                    prio_q;
    logic                    grant_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [REG_WIDTH-1:0]    wdata_q;
    logic                    aw_done_q;
    logic                    w_done_q;
    logic                    bready_q;
    logic [REG_WIDTH-1:0]    rdata_q;
    logic [1:0]              ack_q;

    logic [1:0]              elig;
    logic                    grant_valid;
    logic                    grant_idx;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [REG_WIDTH-1:0]    sel_wdata;
    logic                    sel_we;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    ar_hs;
    logic                    r_hs;
    logic                    aw_fin;
    logic                    w_fin;

    // The requester being acknowledged this cycle is masked so that a
    // still-high req (or its next transaction) cannot win twice in a row.
    assign elig        = req & ~ack_q;
    assign grant_valid = |elig;
    assign grant_idx   = (elig == 2'b11) ? prio_q : elig[1];

    assign sel_addr  = grant_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                 : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = grant_idx ? req_wdata[2*REG_WIDTH-1:REG_WIDTH]
                                 : req_wdata[REG_WIDTH-1:0];
    assign sel_we    = grant_idx ? req_we[1] : req_we[0];

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID  & WREADY;
    assign b_hs  = BVALID  & BREADY;
    assign ar_hs = ARVALID & ARREADY;
    assign r_hs  = RVALID  & RREADY;

    // AW and W may complete in either order or together.
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q  | w_hs;

    always_comb begin
        state_d = state_q;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        busy    = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (grant_valid) begin
                    state_d = sel_we ? WR : RD;
                end
            end
            WR: begin
                AWVALID = ~aw_done_q;
                WVALID  = ~w_done_q;
                if (aw_fin && w_fin) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                end
            end
            RD: begin
                ARVALID = 1'b1;
                if (ar_hs) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                RREADY = 1'b1;
                if (r_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            grant_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            rdata_q   <= '0;
            ack_q     <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= '0;

            if (state_q == IDLE && grant_valid) begin
                grant_q <= grant_idx;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                prio_q  <= ~grant_idx;
            end

            // Done flags live only while still in WR.
            aw_done_q <= (state_q == WR) && (state_d == WR) && aw_fin;
            w_done_q  <= (state_q == WR) && (state_d == WR) && w_fin;

            // One-cycle-late copy of BVALID; cleared on the handshake
            // edge so it never leaks into the IDLE cycle that follows.
            bready_q <= (state_q == WR_RESP) && BVALID && !b_hs;

            if (r_hs) begin
                rdata_q <= RDATA;
            end

            if (b_hs || r_hs) begin
                ack_q[grant_q] <= 1'b1;
            end
        end
    end

    assign BREADY    = bready_q;
    assign AWADDR    = addr_q;
    assign ARADDR    = addr_q;
    assign WDATA     = wdata_q;
    assign req_ack   = ack_q;
    assign req_rdata = rdata_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: AXI-Lite slave model with
// programmable delays, random requester traffic and a reference memory.
module tb_axi_lite_arbiter;
    localparam int AW = 5;
    localparam int RW = 16;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    logic [1:0]      req = '0;
    logic [1:0]      req_we = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*RW-1:0] req_wdata = '0;
    logic [1:0]      req_ack;
    logic [RW-1:0]   req_rdata;
    logic            busy;
    logic            AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic            AWREADY = 0, WREADY = 0, BVALID = 0;
    logic            ARREADY = 0, RVALID = 0;
    logic [AW-1:0]   AWADDR, ARADDR;
    logic [RW-1:0]   WDATA;
    logic [RW-1:0]   RDATA = '0;

    axi_lite_arbiter #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ack(req_ack),
        .req_rdata(req_rdata), .busy(busy),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA)
    );

    int total = 0;
    int bad = 0;

    logic [RW-1:0] mem [32];
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit aw_got, w_got, bpend, b_fire, rpend, r_fire;
    logic [AW-1:0] cap_aw, cap_ar;
    logic [RW-1:0] cap_w;

    // Slave: decides READY/VALID at each falling edge for the next rise.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = RW'($urandom);
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                AWREADY = 0; WREADY = 0; BVALID = 0;
                ARREADY = 0; RVALID = 0;
                aw_got = 0; w_got = 0; bpend = 0; b_fire = 0;
                rpend = 0; r_fire = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (aw_got && w_got && !bpend) begin
                    mem[cap_aw] = cap_w;
                    bpend = 1; b_cnt = 0;
                end else if (bpend) begin
                    if (b_fire) begin
                        BVALID = 0; bpend = 0; b_fire = 0;
                        aw_got = 0; w_got = 0;
                    end else begin
                        if (!BVALID) begin
                            if (b_cnt >= b_dly) BVALID = 1;
                            else b_cnt++;
                        end
                        if (BVALID && BREADY) b_fire = 1;
                    end
                end
                if (AWVALID && !aw_got) begin
                    AWREADY = (aw_cnt >= aw_dly); aw_cnt++;
                    if (AWREADY) begin aw_got = 1; cap_aw = AWADDR; end
                end else begin
                    AWREADY = 0; aw_cnt = 0;
                end
                if (WVALID && !w_got) begin
                    WREADY = (w_cnt >= w_dly); w_cnt++;
                    if (WREADY) begin w_got = 1; cap_w = WDATA; end
                end else begin
                    WREADY = 0; w_cnt = 0;
                end
                if (rpend) begin
                    if (r_fire) begin
                        RVALID = 0; rpend = 0; r_fire = 0;
                    end else begin
                        if (!RVALID) begin
                            if (r_cnt >= r_dly) begin
                                RVALID = 1; RDATA = mem[cap_ar];
                            end else begin
                                r_cnt++;
                                RDATA = RW'($urandom);
                            end
                        end
                        if (RVALID && RREADY) r_fire = 1;
                    end
                end
                if (ARVALID && !rpend) begin
                    ARREADY = (ar_cnt >= ar_dly); ar_cnt++;
                    if (ARREADY) begin
                        cap_ar = ARADDR; rpend = 1; r_cnt = 0;
                    end
                end else begin
                    ARREADY = 0; ar_cnt = 0;
                end
            end
        end
    end

    task automatic step();
        @(negedge ACLK);
        #1;
    endtask

    task automatic set_req(input int i, input bit we,
                           input logic [AW-1:0] a,
                           input logic [RW-1:0] d);
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*RW +: RW] = d;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESET = 1; req = '0;
        repeat (2) @(negedge ACLK);
        #1;
        ARESET = 0;
    endtask

    task automatic test_reset();
        bit got;
        aw_dly = 0; w_dly = 0; b_dly = 0;
        set_req(0, 1, 5'h1f, 16'h0bad);
        req = 2'b01;
        repeat (2) @(negedge ACLK);
        #1;
        total++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ack, busy} !== 8'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0",
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ack, busy});
        end
        total++;
        if ({AWADDR, WDATA, ARADDR, req_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0",
                     {AWADDR, WDATA, ARADDR, req_rdata});
        end
        ARESET = 0;
        step();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL first_grant busy=%b want=1", busy);
        end
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            if (req_ack !== 2'b00) begin
                got = 1;
                total++;
                if (req_ack !== 2'b01) begin
                    bad++;
                    $display("FAIL reset_ack got=%b want=01", req_ack);
                end
                req = '0;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL reset_ack_timeout got=none want=ack");
        end
        repeat (3) step();
    endtask

    task automatic test_write_basic();
        int awc = 0, wc = 0, brc = 0, acks = 0;
        int first_bv = -1, first_br = -1;
        logic [1:0] ackv = '0;
        aw_dly = 0; w_dly = 0; b_dly = 1;
        cap_aw = 'x; cap_w = 'x;
        set_req(0, 1, 5'h04, 16'hA5A5);
        req = 2'b01;
        for (int c = 0; c < 40; c++) begin
            step();
            if (AWVALID) awc++;
            if (WVALID) wc++;
            if (BVALID && first_bv < 0) first_bv = c;
            if (BREADY) begin
                brc++;
                if (first_br < 0) first_br = c;
            end
            if (req_ack !== 2'b00) begin
                acks++; ackv = req_ack; req = '0;
            end
        end
        total++;
        if (awc != 1 || wc != 1) begin
            bad++;
            $display("FAIL wr_valid_cycles aw=%0d w=%0d want 1 1", awc, wc);
        end
        total++;
        if (brc != 1 || first_bv < 0 || first_br != first_bv + 1) begin
            bad++;
            $display("FAIL wr_bready cnt=%0d at=%0d bv=%0d want 1 at bv+1",
                     brc, first_br, first_bv);
        end
        total++;
        if (acks != 1 || ackv !== 2'b01) begin
            bad++;
            $display("FAIL wr_ack n=%0d v=%b want 1 01", acks, ackv);
        end
        total++;
        if (cap_aw !== 5'h04 || cap_w !== 16'hA5A5) begin
            bad++;
            $display("FAIL wr_bus addr=%h data=%h want 04 a5a5", cap_aw, cap_w);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wr_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_read_basic();
        int acks = 0;
        logic [1:0] ackv = '0;
        logic [RW-1:0] rd = '0;
        mem[8] = 16'h1234;
        ar_dly = 0; r_dly = 2;
        cap_ar = 'x;
        set_req(1, 0, 5'h08, 16'hffff);
        req = 2'b10;
        for (int c = 0; c < 40; c++) begin
            step();
            if (req_ack !== 2'b00) begin
                acks++; ackv = req_ack; rd = req_rdata; req = '0;
            end
        end
        total++;
        if (acks != 1 || ackv !== 2'b10) begin
            bad++;
            $display("FAIL rd_ack n=%0d v=%b want 1 10", acks, ackv);
        end
        total++;
        if (rd !== 16'h1234) begin
            bad++;
            $display("FAIL rd_data got=%h want=1234", rd);
        end
        total++;
        if (req_rdata !== 16'h1234 || cap_ar !== 5'h08) begin
            bad++;
            $display("FAIL rd_hold data=%h addr=%h want 1234 08",
                     req_rdata, cap_ar);
        end
    endtask

    task automatic test_w_delay();
        int awc = 0, wc = 0, last_w = -1, first_br = -1, acks = 0;
        logic [1:0] ackv = '0;
        aw_dly = 0; w_dly = 4; b_dly = 0;
        set_req(0, 1, 5'h03, 16'h5a5a);
        req = 2'b01;
        for (int c = 0; c < 40; c++) begin
            step();
            if (AWVALID) awc++;
            if (WVALID) begin wc++; last_w = c; end
            if (BREADY && first_br < 0) first_br = c;
            if (req_ack !== 2'b00) begin
                acks++; ackv = req_ack; req = '0;
            end
        end
        total++;
        if (awc != 1 || wc != 5) begin
            bad++;
            $display("FAIL wdly_cycles aw=%0d w=%0d want 1 5", awc, wc);
        end
        total++;
        if (first_br <= last_w || acks != 1 || ackv !== 2'b01) begin
            bad++;
            $display("FAIL wdly_order br=%0d lastw=%0d ack=%0d/%b want br>lastw 1/01",
                     first_br, last_w, acks, ackv);
        end
    endtask

    task automatic test_reset_rd_data();
        bit in_rd = 0, got = 0;
        int stray = 0;
        ar_dly = 0; r_dly = 30;
        set_req(1, 0, 5'h09, 16'h0);
        req = 2'b10;
        for (int c = 0; c < 20 && !in_rd; c++) begin
            step();
            if (RREADY) in_rd = 1;
        end
        total++;
        if (!in_rd) begin
            bad++;
            $display("FAIL rst_reach_rd got=no want=RD_DATA");
        end
        ARESET = 1;
        set_req(0, 1, 5'h0a, 16'hc0de);
        req = 2'b11;
        #1;
        total++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ack, busy} !== 8'b0) begin
            bad++;
            $display("FAIL rst_mid_ctrl got=%b want=0",
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ack, busy});
        end
        total++;
        if ({AWADDR, WDATA, ARADDR, req_rdata} !== '0) begin
            bad++;
            $display("FAIL rst_mid_data got=%h want=0",
                     {AWADDR, WDATA, ARADDR, req_rdata});
        end
        for (int c = 0; c < 2; c++) begin
            step();
            if (req_ack !== 2'b00) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL rst_no_ack got=%0d want=0", stray);
        end
        r_dly = 0; w_dly = 0; b_dly = 0;
        ARESET = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            if (req_ack !== 2'b00) begin
                got = 1;
                total++;
                if (req_ack !== 2'b01) begin
                    bad++;
                    $display("FAIL rst_next_grant got=%b want=01", req_ack);
                end
                req = '0;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rst_next_timeout got=none want=ack");
        end
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] ref_mem [32];
        bit            tx_we [2];
        logic [AW-1:0] tx_addr [2];
        logic [RW-1:0] tx_wd [2];
        logic [RW-1:0] last_rd;
        logic [1:0]    exp_ack;
        int cur = 0, done = 0, n_act, g;
        bit gap_chk = 0;
        do_reset();
        for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
        last_rd = '0;
        for (int i = 0; i < 2; i++) begin
            tx_we[i] = 1'($urandom);
            tx_addr[i] = AW'($urandom_range(0, 7));
            tx_wd[i] = RW'($urandom);
            set_req(i, tx_we[i], tx_addr[i], tx_wd[i]);
        end
        cap_aw = 'x; cap_w = 'x; cap_ar = 'x;
        req = 2'b11;
        for (int c = 0; c < 4000 && done < 40; c++) begin
            step();
            n_act = int'(AWVALID | WVALID) + int'(BREADY) +
                    int'(ARVALID) + int'(RREADY);
            total++;
            if (n_act > 1) begin
                bad++;
                $display("FAIL excl active=%0d want<=1", n_act);
            end
            if (gap_chk) begin
                gap_chk = 0;
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_gap busy=%b want=1", busy);
                end
            end
            if (req_ack !== 2'b00) begin
                g = cur;
                exp_ack = (g == 0) ? 2'b01 : 2'b10;
                total++;
                if (req_ack !== exp_ack) begin
                    bad++;
                    $display("FAIL b2b_order got=%b want=%b", req_ack, exp_ack);
                end
                total++;
                if (tx_we[g]) begin
                    ref_mem[tx_addr[g]] = tx_wd[g];
                    if (cap_aw !== tx_addr[g] || cap_w !== tx_wd[g] ||
                        req_rdata !== last_rd) begin
                        bad++;
                        $display("FAIL b2b_wr a=%h d=%h rd=%h want %h %h %h",
                                 cap_aw, cap_w, req_rdata,
                                 tx_addr[g], tx_wd[g], last_rd);
                    end
                end else begin
                    last_rd = ref_mem[tx_addr[g]];
                    if (cap_ar !== tx_addr[g] || req_rdata !== last_rd) begin
                        bad++;
                        $display("FAIL b2b_rd a=%h rd=%h want %h %h",
                                 cap_ar, req_rdata, tx_addr[g], last_rd);
                    end
                end
                cap_aw = 'x; cap_w = 'x; cap_ar = 'x;
                tx_we[g] = 1'($urandom);
                tx_addr[g] = AW'($urandom_range(0, 7));
                tx_wd[g] = RW'($urandom);
                set_req(g, tx_we[g], tx_addr[g], tx_wd[g]);
                aw_dly = $urandom_range(0, 3);
                w_dly = $urandom_range(0, 3);
                b_dly = $urandom_range(0, 3);
                ar_dly = $urandom_range(0, 3);
                r_dly = $urandom_range(0, 3);
                cur = 1 - g;
                done++;
                gap_chk = 1;
            end else if (busy) begin
                set_req(cur, 1'($urandom), AW'($urandom), RW'($urandom));
            end
        end
        total++;
        if (done < 40) begin
            bad++;
            $display("FAIL b2b_timeout done=%0d want=40", done);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_w_delay();
        test_reset_rd_data();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
